daq_evt_builder: RTL and testbench

//  Downstream neighbour of the DAQ ring buffer.

---
 rtl/daq_evt_builder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_daq_evt_builder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_evt_builder.sv
// daq_evt_builder: frames ring-buffer samples into header/data/trailer events.
// Optional EVT_CRC_EN appends a CRC-16/CCITT word after the trailer.
module daq_evt_builder #(
  parameter int WORDS_PER_SMP = 16,
  parameter int DATA_AW       = 11,
  parameter int HDR_AW        = 3,
  parameter int AMT_THRESH    = 16,
  parameter int AFL_MARGIN    = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SAMP_MAX,
  input  logic [36:0] L1A_EVT_DATA,
  input  logic        L1A_EVT_PUSH,
  input  logic [17:0] RDATA,
  input  logic        DATA_PUSH,
  output logic [17:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        EVT_BUF_AMT,
  output logic        EVT_BUF_AFL,
  output logic        HDR_OVF,
  output logic        DATA_OVF,
  output logic [15:0] FRAME_CNT
);

  localparam int DDEPTH = 1 << DATA_AW;
  localparam int HDEPTH = 1 << HDR_AW;
`ifdef EVT_CRC_EN
  localparam int WADD = 6;
`else
  localparam int WADD = 5;
`endif

  typedef logic [DATA_AW:0] dcnt_t;
  typedef logic [HDR_AW:0]  hcnt_t;

  localparam dcnt_t DFULL   = dcnt_t'(DDEPTH);
  localparam dcnt_t AMT_LIM = dcnt_t'(AMT_THRESH);
  localparam dcnt_t AFL_LIM = dcnt_t'(DDEPTH - AFL_MARGIN);
  localparam hcnt_t HFULL   = hcnt_t'(HDEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef EVT_CRC_EN
    S_TRL,
    S_CRC
`else
    S_TRL
`endif
  } state_t;

  logic [17:0] dmem [DDEPTH];
  logic [36:0] hmem [HDEPTH];

  logic [DATA_AW-1:0] dwp_q, dwp_d, drp_q, drp_d;
  dcnt_t              dcnt_q, dcnt_d;
  logic [HDR_AW-1:0]  hwp_q, hwp_d, hrp_q, hrp_d;
  hcnt_t              hcnt_q, hcnt_d;
  logic               dovf_q, dovf_d, hovf_q, hovf_d;
  logic               amt_q, amt_d, afl_q, afl_d;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [13:0] rem_q, rem_d;
  logic [13:0] n_q, n_d;
  logic [36:0] desc_q, desc_d;
  logic [6:0]  smp_q, smp_d;
  logic [17:0] dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [15:0] fcnt_q, fcnt_d;
`ifdef EVT_CRC_EN
  logic [15:0] crc_q, crc_d;
`endif

  logic        d_push_ok, h_push_ok;
  logic        d_pop, h_pop;
  logic [13:0] n_cur;
  logic        start;
  logic        ld_ok, ld_en, ld_last;
  logic [17:0] ld_word, hdr_w;
  logic [13:0] wcnt;

`ifdef EVT_CRC_EN
  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction
`endif

  assign d_push_ok = DATA_PUSH && (dcnt_q != DFULL);
  assign h_push_ok = L1A_EVT_PUSH && (hcnt_q != HFULL);
  assign n_cur = 14'(SAMP_MAX) * 14'(WORDS_PER_SMP);
  assign start = (hcnt_q != '0) && (14'(dcnt_q) >= n_cur);
  assign ld_ok = !valid_q || DOUT_READY;
  assign wcnt  = n_q + 14'(WADD);

  // FIFO pointer/count bookkeeping, sticky overflows and occupancy flags
  always_comb begin
    dwp_d  = dwp_q;
    drp_d  = drp_q;
    dcnt_d = dcnt_q;
    hwp_d  = hwp_q;
    hrp_d  = hrp_q;
    hcnt_d = hcnt_q;
    dovf_d = dovf_q | (DATA_PUSH && !d_push_ok);
    hovf_d = hovf_q | (L1A_EVT_PUSH && !h_push_ok);
    amt_d  = dcnt_q < AMT_LIM;
    afl_d  = dcnt_q >= AFL_LIM;
    if (d_push_ok) dwp_d = dwp_q + 1'b1;
    if (d_pop)     drp_d = drp_q + 1'b1;
    if (d_push_ok && !d_pop)
      dcnt_d = dcnt_q + 1'b1;
    else if (!d_push_ok && d_pop)
      dcnt_d = dcnt_q - 1'b1;
    if (h_push_ok) hwp_d = hwp_q + 1'b1;
    if (h_pop)     hrp_d = hrp_q + 1'b1;
    if (h_push_ok && !h_pop)
      hcnt_d = hcnt_q + 1'b1;
    else if (!h_push_ok && h_pop)
      hcnt_d = hcnt_q - 1'b1;
  end

  // header word selected by the header index
  always_comb begin
    hdr_w = '0;
    unique case (idx_q)
      2'd0: hdr_w = {6'h2A, desc_q[23:12]};
      2'd1: hdr_w = {6'h2A, desc_q[11:0]};
      2'd2: hdr_w = {6'h2B, desc_q[35:24]};
      2'd3: hdr_w = {6'h2C, 4'h0, desc_q[36], smp_q};
    endcase
  end

  // frame FSM: picks the next word and loads it into the output register
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    n_d     = n_q;
    desc_d  = desc_q;
    smp_d   = smp_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    d_pop   = 1'b0;
    h_pop   = 1'b0;
    ld_en   = 1'b0;
    ld_last = 1'b0;
    ld_word = '0;
`ifdef EVT_CRC_EN
    crc_d   = crc_q;
`endif
    if (valid_q && DOUT_READY) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (last_q) fcnt_d = fcnt_q + 16'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          h_pop   = 1'b1;
          desc_d  = hmem[hrp_q];
          smp_d   = SAMP_MAX;
          n_d     = n_cur;
          idx_d   = '0;
          state_d = S_HDR;
`ifdef EVT_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end
      end
      S_HDR: begin
        if (ld_ok) begin
          ld_en   = 1'b1;
          ld_word = hdr_w;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            rem_d   = n_q;
            state_d = (n_q == '0) ? S_TRL : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (ld_ok) begin
          ld_en   = 1'b1;
          ld_word = dmem[drp_q];
          d_pop   = 1'b1;
          rem_d   = rem_q - 14'd1;
          if (rem_q == 14'd1) state_d = S_TRL;
        end
      end
      S_TRL: begin
        if (ld_ok) begin
          ld_en   = 1'b1;
          ld_word = {4'hE, wcnt};
`ifdef EVT_CRC_EN
          state_d = S_CRC;
`else
          ld_last = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
`ifdef EVT_CRC_EN
      S_CRC: begin
        if (ld_ok) begin
          ld_en   = 1'b1;
          ld_word = {2'b11, crc_q};
          ld_last = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (ld_en) begin
      dout_d  = ld_word;
      valid_d = 1'b1;
      last_d  = ld_last;
`ifdef EVT_CRC_EN
      if (state_q != S_CRC)
        crc_d = crc_upd(crc_q, ld_word[15:0]);
`endif
    end
  end

  // FIFO storage writes; pointers decide what is live
  always_ff @(posedge CLK) begin
    if (d_push_ok) dmem[dwp_q] <= RDATA;
    if (h_push_ok) hmem[hwp_q] <= L1A_EVT_DATA;
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      dwp_q   <= '0;
      drp_q   <= '0;
      dcnt_q  <= '0;
      hwp_q   <= '0;
      hrp_q   <= '0;
      hcnt_q  <= '0;
      dovf_q  <= 1'b0;
      hovf_q  <= 1'b0;
      amt_q   <= 1'b1;
      afl_q   <= 1'b0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      desc_q  <= '0;
      smp_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fcnt_q  <= '0;
`ifdef EVT_CRC_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      dwp_q   <= dwp_d;
      drp_q   <= drp_d;
      dcnt_q  <= dcnt_d;
      hwp_q   <= hwp_d;
      hrp_q   <= hrp_d;
      hcnt_q  <= hcnt_d;
      dovf_q  <= dovf_d;
      hovf_q  <= hovf_d;
      amt_q   <= amt_d;
      afl_q   <= afl_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      desc_q  <= desc_d;
      smp_q   <= smp_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
`ifdef EVT_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign DOUT        = dout_q;
  assign DOUT_VALID  = valid_q;
  assign EVT_BUF_AMT = amt_q;
  assign EVT_BUF_AFL = afl_q;
  assign HDR_OVF     = hovf_q;
  assign DATA_OVF    = dovf_q;
  assign FRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_daq_evt_builder.sv
// tb_daq_evt_builder: directed bench for the event builder.
// Expected frames are assembled from the header/trailer formulas.
module tb_daq_evt_builder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  SAMP_MAX;
  logic [36:0] L1A_EVT_DATA;
  logic        L1A_EVT_PUSH;
  logic [17:0] RDATA;
  logic        DATA_PUSH;
  logic [17:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  logic        EVT_BUF_AMT;
  logic        EVT_BUF_AFL;
  logic        HDR_OVF;
  logic        DATA_OVF;
  logic [15:0] FRAME_CNT;

  int checks   = 0;
  int failures = 0;
  logic [17:0] exp_q [$];

`ifdef EVT_CRC_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  daq_evt_builder dut (
    .CLK          (CLK),
    .RST          (RST),
    .SAMP_MAX     (SAMP_MAX),
    .L1A_EVT_DATA (L1A_EVT_DATA),
    .L1A_EVT_PUSH (L1A_EVT_PUSH),
    .RDATA        (RDATA),
    .DATA_PUSH    (DATA_PUSH),
    .DOUT         (DOUT),
    .DOUT_VALID   (DOUT_VALID),
    .DOUT_READY   (DOUT_READY),
    .EVT_BUF_AMT  (EVT_BUF_AMT),
    .EVT_BUF_AFL  (EVT_BUF_AFL),
    .HDR_OVF      (HDR_OVF),
    .DATA_OVF     (DATA_OVF),
    .FRAME_CNT    (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic add_frame(
    input logic [36:0] d,
    input logic [6:0]  smp,
    input int          base
  );
    logic [17:0] w [$];
    logic [15:0] c;
    int n;
    n = int'(smp) * 16;
    w.push_back({6'h2A, d[23:12]});
    w.push_back({6'h2A, d[11:0]});
    w.push_back({6'h2B, d[35:24]});
    w.push_back({6'h2C, 4'h0, d[36], smp});
    for (int i = 0; i < n; i++) w.push_back(18'(base + i));
    w.push_back({4'hE, 14'(n + 5 + EXTRA)});
    c = 16'hFFFF;
    foreach (w[i]) begin
      c = crc_ref(c, w[i][15:0]);
      exp_q.push_back(w[i]);
    end
    if (EXTRA == 1) exp_q.push_back({2'b11, c});
  endtask

  task automatic push_desc(input logic [36:0] d);
    L1A_EVT_DATA = d;
    L1A_EVT_PUSH = 1'b1;
    step();
    L1A_EVT_PUSH = 1'b0;
  endtask

  task automatic push_data(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      RDATA     = 18'(base + i);
      DATA_PUSH = 1'b1;
      step();
    end
    DATA_PUSH = 1'b0;
  endtask

  task automatic collect(input bit tgl);
    int cyc;
    bit stall;
    logic [17:0] held;
    cyc   = 0;
    stall = 1'b0;
    held  = '0;
    DOUT_READY = 1'b1;
    while (exp_q.size() > 0 && cyc < 4000) begin
      if (tgl) DOUT_READY = 1'((cyc + 1) & 1);
      if (stall) begin
        chk("hold_valid", 32'(DOUT_VALID), 32'd1);
        chk("hold_data", 32'(DOUT), 32'(held));
      end
      stall = DOUT_VALID && !DOUT_READY;
      held  = DOUT;
      if (DOUT_VALID && DOUT_READY)
        chk("frame_word", 32'(DOUT), 32'(exp_q.pop_front()));
      step();
      cyc++;
    end
    DOUT_READY = 1'b0;
    chk("collect_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!DOUT_VALID && t < 200) begin
      step();
      t++;
    end
    chk("wait_valid", 32'(DOUT_VALID), 32'd1);
  endtask

  initial begin
    logic [36:0] d1, d2, dx;
    RST          = 1'b1;
    SAMP_MAX     = '0;
    L1A_EVT_DATA = '0;
    L1A_EVT_PUSH = 1'b0;
    RDATA        = '0;
    DATA_PUSH    = 1'b0;
    DOUT_READY   = 1'b0;
    repeat (3) step();

    // reset values
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_valid", 32'(DOUT_VALID), 32'd0);
    chk("rst_amt", 32'(EVT_BUF_AMT), 32'd1);
    chk("rst_afl", 32'(EVT_BUF_AFL), 32'd0);
    chk("rst_hovf", 32'(HDR_OVF), 32'd0);
    chk("rst_dovf", 32'(DATA_OVF), 32'd0);
    chk("rst_fcnt", 32'(FRAME_CNT), 32'd0);
    RST = 1'b0;
    step();

    // basic frame
    d1 = {1'b1, 12'h123, 24'h00ABCD};
    SAMP_MAX = 7'd2;
    push_desc(d1);
    push_data(0, 32);
    add_frame(d1, 7'd2, 0);
    chk("t1_h0", 32'(exp_q[0]), 32'h2A00A);
    chk("t1_h3", 32'(exp_q[3]), 32'h2C082);
    collect(1'b0);
    chk("t1_fcnt", 32'(FRAME_CNT), 32'd1);

    // frame waits for the full data count, then 2-cycle latency
    d2 = {1'b0, 12'h055, 24'h123456};
    push_desc(d2);
    push_data(100, 31);
    repeat (5) step();
    chk("t2_short", 32'(DOUT_VALID), 32'd0);
    RDATA     = 18'(131);
    DATA_PUSH = 1'b1;
    step();
    DATA_PUSH = 1'b0;
    chk("t2_lat0", 32'(DOUT_VALID), 32'd0);
    step();
    chk("t2_lat1", 32'(DOUT_VALID), 32'd0);
    step();
    chk("t2_lat2", 32'(DOUT_VALID), 32'd1);
    chk("t2_h0", 32'(DOUT), 32'h2A123);
    add_frame(d2, 7'd2, 100);
    collect(1'b0);
    chk("t2_fcnt", 32'(FRAME_CNT), 32'd2);

    // backpressure toggling
    push_desc(d1);
    push_data(0, 32);
    add_frame(d1, 7'd2, 0);
    collect(1'b1);
    chk("t3_fcnt", 32'(FRAME_CNT), 32'd3);

    // descriptor FIFO overflow
    SAMP_MAX = 7'd1;
    for (int i = 0; i < 9; i++) begin
      dx[36]    = 1'(i & 1);
      dx[35:24] = 12'(256 + i);
      dx[23:0]  = 24'(65536 * i + 3 * i);
      push_desc(dx);
      if (i == 7) chk("t4_hovf8", 32'(HDR_OVF), 32'd0);
    end
    chk("t4_hovf9", 32'(HDR_OVF), 32'd1);
    push_data(4096, 128);
    for (int i = 0; i < 8; i++) begin
      dx[36]    = 1'(i & 1);
      dx[35:24] = 12'(256 + i);
      dx[23:0]  = 24'(65536 * i + 3 * i);
      add_frame(dx, 7'd1, 4096 + 16 * i);
    end
    collect(1'b0);
    repeat (10) step();
    chk("t4_nomore", 32'(DOUT_VALID), 32'd0);
    chk("t4_fcnt", 32'(FRAME_CNT), 32'd11);

    // occupancy flags and data overflow
    chk("t5_amt0", 32'(EVT_BUF_AMT), 32'd1);
    for (int k = 1; k <= 2048; k++) begin
      RDATA     = 18'(k);
      DATA_PUSH = 1'b1;
      step();
      if (k == 16)   chk("t5_amt15", 32'(EVT_BUF_AMT), 32'd1);
      if (k == 17)   chk("t5_amt16", 32'(EVT_BUF_AMT), 32'd0);
      if (k == 1984) chk("t5_afl1983", 32'(EVT_BUF_AFL), 32'd0);
      if (k == 1985) chk("t5_afl1984", 32'(EVT_BUF_AFL), 32'd1);
    end
    chk("t5_dovf_full", 32'(DATA_OVF), 32'd0);
    step();
    DATA_PUSH = 1'b0;
    chk("t5_dovf", 32'(DATA_OVF), 32'd1);
    chk("t5_afl", 32'(EVT_BUF_AFL), 32'd1);
    step();
    chk("t5_dovf_sticky", 32'(DATA_OVF), 32'd1);

    // zero-length frame after reset
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    chk("t6_rst_dovf", 32'(DATA_OVF), 32'd0);
    chk("t6_rst_fcnt", 32'(FRAME_CNT), 32'd0);
    step();
    chk("t6_rst_amt", 32'(EVT_BUF_AMT), 32'd1);
    SAMP_MAX = 7'd0;
    push_desc(d2);
    add_frame(d2, 7'd0, 0);
    chk("t6_wcnt", 32'(exp_q[4]), 32'(18'h38000 + 5 + EXTRA));
    collect(1'b0);
    chk("t6_fcnt", 32'(FRAME_CNT), 32'd1);

    // reset in the middle of the data section
    SAMP_MAX = 7'd2;
    push_desc(d1);
    push_data(1280, 32);
    wait_valid();
    DOUT_READY = 1'b1;
    repeat (6) step();
    RST        = 1'b1;
    DOUT_READY = 1'b0;
    step();
    RST = 1'b0;
    chk("t6_mid_valid", 32'(DOUT_VALID), 32'd0);
    chk("t6_mid_dout", 32'(DOUT), 32'd0);
    chk("t6_mid_fcnt", 32'(FRAME_CNT), 32'd0);
    step();
    chk("t6_mid_amt", 32'(EVT_BUF_AMT), 32'd1);
    push_data(1536, 32);
    repeat (10) step();
    chk("t6_hdr_empty", 32'(DOUT_VALID), 32'd0);
    push_desc(d2);
    add_frame(d2, 7'd2, 1536);
    collect(1'b0);
    chk("t6_end_fcnt", 32'(FRAME_CNT), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
